// File: rtl/iuq_ram_pkg.sv
// rtl/iuq_ram_pkg.sv - shared state encoding, command layout and defaults for the IU RAM sequencer
package iuq_ram_pkg;

  localparam int INSTR_W       = 32;
  localparam int EXT_W         = 4;
  localparam int CMD_W         = INSTR_W + EXT_W;
  localparam int DEF_MAX_FLUSH = 3;
  localparam int DEF_TMO_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } ram_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [EXT_W-1:0]   ext;
  } ram_cmd_t;

  function automatic ram_cmd_t split_cmd(input logic [CMD_W-1:0] raw);
    return ram_cmd_t'(raw);
  endfunction

endpackage

// File: rtl/iuq_ram_rr_arb.sv
// rtl/iuq_ram_rr_arb.sv - round-robin arbiter: first request at or after the pointer, with wrap
module iuq_ram_rr_arb #(
  parameter int REQS  = 2,
  parameter int IDX_W = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic [REQS-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [REQS-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_j;

  // Walk from the farthest slot back to the pointer so the nearest request is written last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = '0;
    for (int k = REQS - 1; k >= 0; k--) begin
      w_j = IDX_W'((int'(i_ptr) + k) % REQS);
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/iuq_ram_ctrl.sv
// rtl/iuq_ram_ctrl.sv - arbitrates requester RAM commands and sequences issue, wait and completion
// Requester i and thread t sit at bit (N-1-i) of their vectors, matching MSB-first rq_instr packing.
module iuq_ram_ctrl
  import iuq_ram_pkg::*;
#(
  parameter int THREADS   = 2,
  parameter int REQS      = 2,
  parameter int TID_W     = (THREADS > 1) ? $clog2(THREADS) : 1,
  parameter int MAX_FLUSH = DEF_MAX_FLUSH,
  parameter int TMO_W     = DEF_TMO_W
) (
  input  logic                    nclk,
  input  logic                    nrst,
  input  logic [REQS-1:0]         rq_val,
  input  logic [REQS*CMD_W-1:0]   rq_instr,
  input  logic [REQS*TID_W-1:0]   rq_tid,
  output logic [REQS-1:0]         rq_ack,
  output logic [REQS-1:0]         rq_done,
  output logic [REQS-1:0]         rq_err,
  input  logic [TMO_W-1:0]        tmo_limit,
  output logic [INSTR_W-1:0]      pc_iu_ram_instr,
  output logic [EXT_W-1:0]        pc_iu_ram_instr_ext,
  output logic                    pc_iu_ram_issue,
  output logic [THREADS-1:0]      pc_iu_ram_active,
  input  logic                    iu_pc_ram_done,
  input  logic [THREADS-1:0]      cp_flush,
  output logic                    ram_busy
);

  localparam int IDX_W = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int FL_W  = $clog2(MAX_FLUSH + 1);

  ram_state_e       r_state;
  ram_state_e       w_next;
  ram_cmd_t         r_cmd;
  logic [TID_W-1:0] r_tid;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [FL_W-1:0]  r_flush_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_ok;

  logic [REQS-1:0]  w_req;
  logic [REQS-1:0]  w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic [CMD_W-1:0] w_sel_cmd;
  logic [TID_W-1:0] w_sel_tid;
  logic             w_grant;
  logic             w_own_flush;
  logic             w_abort;
  logic             w_active_on;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < REQS; i++) w_req[i] = rq_val[REQS-1-i];
  end

  iuq_ram_rr_arb #(
    .REQS  (REQS),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_sel_cmd = '0;
    w_sel_tid = '0;
    for (int i = 0; i < REQS; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_cmd = rq_instr[(REQS-1-i)*CMD_W +: CMD_W];
        w_sel_tid = rq_tid[(REQS-1-i)*TID_W +: TID_W];
      end
    end
  end

  assign w_grant     = (r_state == ST_IDLE) && (|w_req);
  assign w_active_on = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_abort     = (r_flush_cnt == FL_W'(MAX_FLUSH)) ||
                       ((tmo_limit != '0) && (r_tmo_cnt == tmo_limit));

  always_comb begin
    w_own_flush      = 1'b0;
    pc_iu_ram_active = '0;
    for (int t = 0; t < THREADS; t++) begin
      if (r_tid == TID_W'(t)) begin
        w_own_flush                  = cp_flush[THREADS-1-t];
        pc_iu_ram_active[THREADS-1-t] = w_active_on;
      end
    end
  end

  // Ack is gated by reset so every output reads zero while nrst is held low.
  always_comb begin
    rq_ack  = '0;
    rq_done = '0;
    rq_err  = '0;
    for (int i = 0; i < REQS; i++) begin
      rq_ack[REQS-1-i]  = nrst && w_grant && w_gnt[i];
      rq_done[REQS-1-i] = (r_state == ST_FIN) && r_ok && (r_owner == IDX_W'(i));
      rq_err[REQS-1-i]  = (r_state == ST_FIN) && !r_ok && (r_owner == IDX_W'(i));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (iu_pc_ram_done || w_abort) w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge nclk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_tid       <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_flush_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_ok        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_cmd       <= split_cmd(w_sel_cmd);
        r_tid       <= w_sel_tid;
        r_owner     <= w_idx;
        r_rr_ptr    <= (w_idx == IDX_W'(REQS - 1)) ? '0 : w_idx + 1'b1;
        r_flush_cnt <= '0;
        r_tmo_cnt   <= '0;
      end
      // A flush stalls the timeout count; the RAM unit replays without a new issue.
      if (r_state == ST_WAIT) begin
        r_ok <= iu_pc_ram_done;
        if (!iu_pc_ram_done && !w_abort) begin
          if (w_own_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
          else if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end
    end
  end

  assign pc_iu_ram_instr     = r_cmd.instr;
  assign pc_iu_ram_instr_ext = r_cmd.ext;
  assign pc_iu_ram_issue     = (r_state == ST_ISSUE);
  assign ram_busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_iuq_ram_ctrl.sv
// tb/tb_iuq_ram_ctrl.sv - randomized scoreboard bench for the IU RAM command sequencer
module tb_iuq_ram_ctrl;

  localparam int MAXC      = 4096;
  localparam int MAX_FLUSH = 3;

  logic         nclk = 1'b0;
  logic         nrst = 1'b0;
  logic [1:0]   rq_val = '0;
  logic [71:0]  rq_instr = '0;
  logic [1:0]   rq_tid = '0;
  logic [1:0]   rq_ack, rq_done, rq_err;
  logic [7:0]   tmo_limit = '0;
  logic [31:0]  pc_iu_ram_instr;
  logic [3:0]   pc_iu_ram_instr_ext;
  logic         pc_iu_ram_issue;
  logic [1:0]   pc_iu_ram_active;
  logic         iu_pc_ram_done = 1'b0;
  logic [1:0]   cp_flush = '0;
  logic         ram_busy;

  iuq_ram_ctrl #(.THREADS(2), .REQS(2), .TID_W(1), .MAX_FLUSH(MAX_FLUSH), .TMO_W(8)) dut (
    .nclk(nclk), .nrst(nrst), .rq_val(rq_val), .rq_instr(rq_instr), .rq_tid(rq_tid),
    .rq_ack(rq_ack), .rq_done(rq_done), .rq_err(rq_err), .tmo_limit(tmo_limit),
    .pc_iu_ram_instr(pc_iu_ram_instr), .pc_iu_ram_instr_ext(pc_iu_ram_instr_ext),
    .pc_iu_ram_issue(pc_iu_ram_issue), .pc_iu_ram_active(pc_iu_ram_active),
    .iu_pc_ram_done(iu_pc_ram_done), .cp_flush(cp_flush), .ram_busy(ram_busy)
  );

  always #5 nclk = ~nclk;

  int cyc = 0;
  always @(posedge nclk) cyc <= cyc + 1;

  typedef struct {
    logic [35:0] cmd;
    int          tid;
    int          done_at;
    logic [63:0] fmask;
    logic [63:0] omask;
  } cmd_t;

  typedef struct {
    int          c;
    logic [63:0] v;
  } exp_t;

  exp_t q_ack[$], q_iss[$], q_fin[$];
  cmd_t q0[$], q1[$];
  cmd_t cur[2];
  logic [1:0] val = '0;
  int drop_g = -1;
  int m_ptr = 0;
  int m_idle_at = 0;

  logic       sched_done [MAXC];
  logic [1:0] sched_fl   [MAXC];
  logic [2:0] exp_ab     [MAXC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {rq_ack, rq_done, rq_err, pc_iu_ram_issue, pc_iu_ram_active, ram_busy,
             pc_iu_ram_instr, pc_iu_ram_instr_ext}, 64'd0);
  endtask

  // Outcome of one command from its WAIT-cycle event plan: index of the deciding WAIT cycle and success.
  function automatic void outcome(input int done_at, input logic [63:0] fm, input int lim,
                                  output int end_w, output bit ok);
    int fl = 0;
    int t = 0;
    end_w = 2000;
    ok = 1'b0;
    for (int w = 0; w < 2000; w++) begin
      if (w == done_at) begin end_w = w; ok = 1'b1; return; end
      if (fl >= MAX_FLUSH || (lim != 0 && t == lim)) begin end_w = w; ok = 1'b0; return; end
      if (w < 64 && fm[w]) fl++;
      else if (t < 255) t++;
    end
  endfunction

  function automatic cmd_t mk(input int tid, input int da, input logic [63:0] fm, input logic [63:0] om);
    cmd_t t;
    t.cmd     = {32'($urandom()), 4'($urandom_range(0, 15))};
    t.tid     = tid;
    t.done_at = da;
    t.fmask   = fm;
    t.omask   = om;
    return t;
  endfunction

  task automatic clear_from(input int c0);
    for (int i = c0; i < MAXC; i++) begin
      sched_done[i] = 1'b0;
      sched_fl[i]   = '0;
      exp_ab[i]     = '0;
    end
  endtask

  task automatic run_traffic(input int lim, input int max_cyc, input int raise_pct, input int retract_pct);
    int t0, c, g, end_w, is_c, fin_c, cw;
    bit ok;
    bit held [2];
    logic [1:0] oh, act, oth, f;
    t0 = cyc;
    tmo_limit = 8'(lim);
    while ((q0.size() > 0 || q1.size() > 0 || val != 0 || cyc < m_idle_at) && cyc < t0 + max_cyc) begin
      @(posedge nclk); #2;
      c = cyc;
      if (drop_g >= 0) begin val[drop_g] = 1'b0; drop_g = -1; end
      for (int r = 0; r < 2; r++) begin
        held[r] = 1'b0;
        if (val[r] && $urandom_range(0, 99) < retract_pct) begin
          val[r] = 1'b0;
          held[r] = 1'b1;
          if (r == 0) q0.push_front(cur[0]); else q1.push_front(cur[1]);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (!val[r] && !held[r] && $urandom_range(0, 99) < raise_pct) begin
          if (r == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); val[0] = 1'b1; end
          if (r == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); val[1] = 1'b1; end
        end
      end
      rq_val         = {val[0], val[1]};
      rq_instr       = {cur[0].cmd, cur[1].cmd};
      rq_tid         = {1'(cur[0].tid), 1'(cur[1].tid)};
      iu_pc_ram_done = sched_done[c];
      cp_flush       = sched_fl[c];
      if (c >= m_idle_at && val != 0) begin
        g = -1;
        for (int k = 0; k < 2; k++) if (g < 0 && val[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
        outcome(cur[g].done_at, cur[g].fmask, lim, end_w, ok);
        is_c  = c + 1;
        fin_c = c + 3 + end_w;
        oh    = 2'b10 >> g;
        act   = 2'b10 >> cur[g].tid;
        oth   = 2'b10 >> (1 - cur[g].tid);
        q_ack.push_back('{c, 64'(oh)});
        q_iss.push_back('{is_c, 64'({cur[g].cmd, act})});
        q_fin.push_back('{fin_c, ok ? 64'({oh, 2'b00}) : 64'({2'b00, oh})});
        for (int w = 0; w <= end_w; w++) begin
          cw = c + 2 + w;
          f = '0;
          if (w < 64 && cur[g].fmask[w]) f = f | act;
          if (w < 64 && cur[g].omask[w]) f = f | oth;
          if (cw < MAXC) begin
            sched_done[cw] = (w == cur[g].done_at);
            sched_fl[cw]   = f;
          end
        end
        for (int x = is_c; x < fin_c && x < MAXC; x++) exp_ab[x] = {act, 1'b1};
        if (fin_c < MAXC) exp_ab[fin_c] = 3'b001;
        m_idle_at = fin_c + 1;
        m_ptr     = (g + 1) % 2;
        drop_g    = g;
      end
    end
    @(posedge nclk); #2;
    rq_val         = '0;
    iu_pc_ram_done = 1'b0;
    cp_flush       = '0;
  endtask

  exp_t m_e;
  always @(negedge nclk) begin
    if (nrst) begin
      if (cyc < MAXC) chk("active_busy", {pc_iu_ram_active, ram_busy}, 64'(exp_ab[cyc]));
      if (rq_ack != 0) begin
        if (q_ack.size() == 0) chk("ack_unexpected", 64'(rq_ack), 64'd0);
        else begin
          m_e = q_ack.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(m_e.c));
          chk("ack_vec", 64'(rq_ack), m_e.v);
        end
      end
      if (pc_iu_ram_issue) begin
        if (q_iss.size() == 0) chk("issue_unexpected", 64'(pc_iu_ram_issue), 64'd0);
        else begin
          m_e = q_iss.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(m_e.c));
          chk("issue_cmd_active", 64'({pc_iu_ram_instr, pc_iu_ram_instr_ext, pc_iu_ram_active}), m_e.v);
        end
      end
      if ((rq_done | rq_err) != 0) begin
        if (q_fin.size() == 0) chk("fin_unexpected", 64'({rq_done, rq_err}), 64'd0);
        else begin
          m_e = q_fin.pop_front();
          chk("fin_cycle", 64'(cyc), 64'(m_e.c));
          chk("fin_done_err", 64'({rq_done, rq_err}), m_e.v);
        end
      end
    end
  end

  initial begin
    #40000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lim, da;
    logic [63:0] fm, om;
    cmd_t tmp;
    cur[0] = mk(0, 0, 0, 0);
    cur[1] = mk(0, 0, 0, 0);
    clear_from(0);
    rq_val = 2'b11;
    #3;
    chk_zero("reset_outputs");
    rq_val = '0;
    @(posedge nclk); #2;
    nrst = 1'b1;

    // Both requesters pending from pointer 0: r0, r1, r0, r1.
    q0.push_back(mk(0, 2, 0, 0)); q0.push_back(mk(1, 1, 0, 0));
    q1.push_back(mk(1, 3, 0, 0)); q1.push_back(mk(0, 0, 0, 0));
    run_traffic(0, 200, 100, 0);

    // Requester 0, thread 1, done five cycles after issue.
    q0.push_back(mk(1, 4, 0, 0));
    run_traffic(0, 100, 100, 0);

    // Two owning flushes then done; foreign-thread flushes in between.
    q1.push_back(mk(0, 6, 64'b1010, 64'b10101));
    run_traffic(0, 100, 100, 0);

    // Timeout at limit 4, and limit 0 waiting 300 cycles for done.
    q0.push_back(mk(1, -1, 0, 0));
    run_traffic(4, 100, 100, 0);
    q1.push_back(mk(1, 300, 0, 0));
    run_traffic(0, 400, 100, 0);

    // Done coinciding with timeout hit and with flush-limit hit; flush limit alone.
    q0.push_back(mk(0, 4, 64'b10000, 0));
    run_traffic(4, 100, 100, 0);
    q1.push_back(mk(1, 3, 64'b111, 0));
    q0.push_back(mk(0, -1, 64'b111, 0));
    run_traffic(0, 100, 100, 0);

    for (int ch = 0; ch < 4; ch++) begin
      lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 8));
      for (int i = 0; i < 10; i++) begin
        fm = '0; om = '0;
        for (int b = 0; b < 16; b++) begin
          if ($urandom_range(0, 99) < 15) fm[b] = 1'b1;
          if ($urandom_range(0, 99) < 15) om[b] = 1'b1;
        end
        da = (lim != 0 && $urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 12));
        tmp = mk(int'($urandom_range(0, 1)), da, fm, om);
        if ($urandom_range(0, 1) == 1) q0.push_back(tmp); else q1.push_back(tmp);
      end
      run_traffic(lim, 1500, 60, 5);
    end

    // Reset while requester 0's command sits in WAIT; afterwards the pointer must be back at 0.
    q0.push_back(mk(0, 40, 0, 0));
    run_traffic(0, 5, 100, 0);
    @(posedge nclk); #3;
    nrst = 1'b0;
    #1;
    chk_zero("reset_mid_wait");
    q_ack.delete(); q_iss.delete(); q_fin.delete();
    clear_from(cyc);
    val = '0; drop_g = -1; m_ptr = 0; m_idle_at = 0;
    repeat (2) begin
      @(negedge nclk);
      chk_zero("reset_held");
    end
    @(posedge nclk); #2;
    nrst = 1'b1;
    q0.push_back(mk(1, 2, 0, 0));
    q1.push_back(mk(0, 1, 0, 0));
    run_traffic(0, 100, 100, 0);

    repeat (4) @(posedge nclk);
    #2;
    chk("ack_queue_left", 64'(q_ack.size()), 64'd0);
    chk("issue_queue_left", 64'(q_iss.size()), 64'd0);
    chk("fin_queue_left", 64'(q_fin.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
